// File: rtl/piece_scan_ctrl_if.sv
// Request/result bundle between the move-request logic and the piece scan sequencer.
// The requester drives start/target/skip fields; the sequencer returns status and results.
interface piece_scan_ctrl_if;
  logic        start;
  logic [4:0]  target;
  logic        skip_en;
  logic [2:0]  skip_idx;
  logic        busy;
  logic        done;
  logic        hit;
  logic [2:0]  hit_idx;
  logic [19:0] occ;
  logic        err;

  modport master (
    output start, target, skip_en, skip_idx,
    input  busy, done, hit, hit_idx, occ, err
  );

  modport slave (
    input  start, target, skip_en, skip_idx,
    output busy, done, hit, hit_idx, occ, err
  );
endinterface

// File: rtl/piece_scan_ctrl.sv
// Walks the piece-position mux one source per cycle, building the board occupancy map
// and testing whether the requested target cell is already taken.
module piece_scan_ctrl #(
  parameter int NUM_SRC = 6,
  parameter int CELLS   = 20
) (
  input  logic                clk,
  input  logic                rst,
  piece_scan_ctrl_if.slave    bus,
  output logic [2:0]          mux_sel,
  input  logic [4:0]          mux_dout
);

  localparam logic [4:0] CELLS_W = 5'(CELLS);
  localparam logic [2:0] LAST_SRC = 3'(NUM_SRC - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state;
  logic [4:0] target_q;
  logic       skip_en_q;
  logic [2:0] skip_idx_q;
  logic       src_skipped;

  assign src_skipped = skip_en_q && (mux_sel == skip_idx_q);

  // An invalid target can never match, because only in-range positions reach the compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mux_sel    <= 3'd0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.hit    <= 1'b0;
      bus.hit_idx <= 3'd0;
      bus.occ    <= 20'd0;
      bus.err    <= 1'b0;
      target_q   <= 5'd0;
      skip_en_q  <= 1'b0;
      skip_idx_q <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          mux_sel  <= 3'd0;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          if (bus.start) begin
            target_q    <= bus.target;
            skip_en_q   <= bus.skip_en;
            skip_idx_q  <= bus.skip_idx;
            bus.occ     <= 20'd0;
            bus.hit     <= 1'b0;
            bus.hit_idx <= 3'd0;
            bus.err     <= (bus.target >= CELLS_W);
            bus.busy    <= 1'b1;
            state       <= SCAN;
          end
        end

        SCAN: begin
          if (!src_skipped) begin
            if (mux_dout >= CELLS_W) begin
              bus.err <= 1'b1;
            end else begin
              bus.occ[mux_dout] <= 1'b1;
              if ((mux_dout == target_q) && !bus.hit) begin
                bus.hit     <= 1'b1;
                bus.hit_idx <= mux_sel;
              end
            end
          end
          if (mux_sel == LAST_SRC) begin
            mux_sel  <= 3'd0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            mux_sel <= mux_sel + 3'd1;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piece_scan_ctrl.sv
// Directed bench for piece_scan_ctrl: a table-driven mux model feeds positions and each
// scenario task compares results against hand-computed values.
module tb_piece_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] mux_sel;
  logic [4:0] mux_dout;
  logic [4:0] pos [0:7];

  int total;
  int bad;

  piece_scan_ctrl_if bus ();

  piece_scan_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mux_sel  (mux_sel),
    .mux_dout (mux_dout)
  );

  assign mux_dout = pos[mux_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_pos(input logic [4:0] p0, p1, p2, p3, p4, p5);
    pos[0] = p0; pos[1] = p1; pos[2] = p2;
    pos[3] = p3; pos[4] = p4; pos[5] = p5;
    pos[6] = 5'd0; pos[7] = 5'd0;
  endtask

  // Starts one scan and observes cycles t+1..t+10; reports when done arrived and busy length.
  task automatic run_scan(input logic [4:0] tgt, input logic sen, input logic [2:0] sidx,
                          output int done_k, output int busy_cnt, output int done_cnt);
    done_k = 0;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.target = tgt;
    bus.skip_en = sen;
    bus.skip_idx = sidx;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({mux_sel, bus.busy, bus.done, bus.hit, bus.hit_idx, bus.err} !== 10'd0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got sel=%0d busy=%b done=%b hit=%b idx=%0d err=%b want all 0",
               mux_sel, bus.busy, bus.done, bus.hit, bus.hit_idx, bus.err);
    end
    total++;
    if (bus.occ !== 20'd0) begin
      bad++;
      $display("[TB] FAIL reset_occ: got %h want 00000", bus.occ);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_hit;
    int dk, bc, dc;
    set_pos(5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9);
    run_scan(5'd5, 1'b0, 3'd0, dk, bc, dc);
    total++;
    if (dk !== 7) begin
      bad++;
      $display("[TB] FAIL basic_latency: done at cycle %0d want 7", dk);
    end
    total++;
    if (bc !== 6) begin
      bad++;
      $display("[TB] FAIL basic_busy: busy cycles %0d want 6", bc);
    end
    total++;
    if (dc !== 1) begin
      bad++;
      $display("[TB] FAIL basic_done_count: %0d want 1", dc);
    end
    total++;
    if ({bus.hit, bus.hit_idx, bus.err, bus.occ} !== {1'b1, 3'd3, 1'b0, 20'h00333}) begin
      bad++;
      $display("[TB] FAIL basic_result: hit=%b idx=%0d err=%b occ=%h want 1 3 0 00333",
               bus.hit, bus.hit_idx, bus.err, bus.occ);
    end
  endtask

  task automatic test_skip;
    int dk, bc, dc;
    set_pos(5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9);
    run_scan(5'd5, 1'b1, 3'd3, dk, bc, dc);
    total++;
    if ({bus.hit, bus.err, bus.occ} !== {1'b0, 1'b0, 20'h00313}) begin
      bad++;
      $display("[TB] FAIL skip_result: hit=%b err=%b occ=%h want 0 0 00313",
               bus.hit, bus.err, bus.occ);
    end
    run_scan(5'd5, 1'b1, 3'd7, dk, bc, dc);
    total++;
    if ({bus.hit, bus.hit_idx, bus.occ} !== {1'b1, 3'd3, 20'h00333}) begin
      bad++;
      $display("[TB] FAIL skip_out_of_range: hit=%b idx=%0d occ=%h want 1 3 00333",
               bus.hit, bus.hit_idx, bus.occ);
    end
  endtask

  task automatic test_duplicates;
    int dk, bc, dc;
    set_pos(5'd2, 5'd2, 5'd7, 5'd7, 5'd12, 5'd19);
    run_scan(5'd7, 1'b0, 3'd0, dk, bc, dc);
    total++;
    if ({bus.hit, bus.hit_idx, bus.err, bus.occ} !== {1'b1, 3'd2, 1'b0, 20'h81084}) begin
      bad++;
      $display("[TB] FAIL dup_result: hit=%b idx=%0d err=%b occ=%h want 1 2 0 81084",
               bus.hit, bus.hit_idx, bus.err, bus.occ);
    end
  endtask

  task automatic test_errors;
    int dk, bc, dc;
    set_pos(5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9);
    run_scan(5'd20, 1'b0, 3'd0, dk, bc, dc);
    total++;
    if ({bus.hit, bus.err, bus.occ} !== {1'b0, 1'b1, 20'h00333} || dk !== 7) begin
      bad++;
      $display("[TB] FAIL bad_target: hit=%b err=%b occ=%h done_k=%0d want 0 1 00333 7",
               bus.hit, bus.err, bus.occ, dk);
    end
    set_pos(5'd0, 5'd1, 5'd4, 5'd5, 5'd25, 5'd9);
    run_scan(5'd0, 1'b0, 3'd0, dk, bc, dc);
    total++;
    if ({bus.hit, bus.hit_idx, bus.err, bus.occ} !== {1'b1, 3'd0, 1'b1, 20'h00233}) begin
      bad++;
      $display("[TB] FAIL bad_source: hit=%b idx=%0d err=%b occ=%h want 1 0 1 00233",
               bus.hit, bus.hit_idx, bus.err, bus.occ);
    end
    run_scan(5'd0, 1'b1, 3'd4, dk, bc, dc);
    total++;
    if ({bus.hit, bus.err, bus.occ} !== {1'b1, 1'b0, 20'h00233}) begin
      bad++;
      $display("[TB] FAIL skipped_bad_source: hit=%b err=%b occ=%h want 1 0 00233",
               bus.hit, bus.err, bus.occ);
    end
  endtask

  task automatic test_mid_reset;
    int dk, bc, dc;
    int done_seen;
    set_pos(5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9);
    @(negedge clk);
    bus.start = 1'b1;
    bus.target = 5'd5;
    bus.skip_en = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || mux_sel !== 3'd2) begin
      bad++;
      $display("[TB] FAIL midscan_state: busy=%b sel=%0d want 1 2", bus.busy, mux_sel);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({mux_sel, bus.busy, bus.done, bus.hit, bus.hit_idx, bus.err} !== 10'd0 ||
        bus.occ !== 20'd0) begin
      bad++;
      $display("[TB] FAIL midscan_reset: sel=%0d busy=%b done=%b hit=%b occ=%h err=%b want all 0",
               mux_sel, bus.busy, bus.done, bus.hit, bus.occ, bus.err);
    end
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.done === 1'b1) done_seen++;
      @(negedge clk);
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("[TB] FAIL aborted_done: %0d pulses want 0", done_seen);
    end
    run_scan(5'd9, 1'b0, 3'd0, dk, bc, dc);
    total++;
    if (dk !== 7 || {bus.hit, bus.hit_idx, bus.occ} !== {1'b1, 3'd5, 20'h00333}) begin
      bad++;
      $display("[TB] FAIL restart_after_reset: done_k=%0d hit=%b idx=%0d occ=%h want 7 1 5 00333",
               dk, bus.hit, bus.hit_idx, bus.occ);
    end
  endtask

  task automatic test_ignored_start;
    int done_cnt;
    int done_k;
    set_pos(5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9);
    done_cnt = 0;
    done_k = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.target = 5'd5;
    bus.skip_en = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
      bus.start = (k == 2) || (k == 7);
      @(negedge clk);
    end
    bus.start = 1'b0;
    total++;
    if (done_cnt !== 1 || done_k !== 7) begin
      bad++;
      $display("[TB] FAIL ignored_start: %0d done pulses first at %0d want 1 at 7",
               done_cnt, done_k);
    end
  endtask

  task automatic test_back_to_back;
    int done_cnt;
    int first_k;
    int second_k;
    set_pos(5'd2, 5'd2, 5'd7, 5'd7, 5'd12, 5'd19);
    done_cnt = 0;
    first_k = 0;
    second_k = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.target = 5'd7;
    bus.skip_en = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 24; k++) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (first_k == 0) first_k = k;
        else if (second_k == 0) second_k = k;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    total++;
    if (done_cnt !== 3 || first_k !== 7 || second_k !== 15) begin
      bad++;
      $display("[TB] FAIL held_start: pulses=%0d at %0d,%0d want 3 at 7,15",
               done_cnt, first_k, second_k);
    end
    repeat (12) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || {bus.hit, bus.hit_idx, bus.occ} !== {1'b1, 3'd2, 20'h81084}) begin
      bad++;
      $display("[TB] FAIL held_start_final: busy=%b hit=%b idx=%0d occ=%h want 0 1 2 81084",
               bus.busy, bus.hit, bus.hit_idx, bus.occ);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.target = 5'd0;
    bus.skip_en = 1'b0;
    bus.skip_idx = 3'd0;
    set_pos(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_basic_hit();
    test_skip();
    test_duplicates();
    test_errors();
    test_mid_reset();
    test_ignored_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
